mapper_port_multicart: RTL and testbench

- I/O-port-controlled multicart ROM mapper, generalising the Zemina 90-in-1 scheme.
- Owns its bank/mode register, which is captured from a Z80 OUT to a parametrised port.
- Translates 4000-BFFF slot reads into 8KB-block ROM addresses, with four addressing modes and ROM-size wrap masking.
- Optional I/O readback of the register.
- Sits in the msx_slots mapper set beside the other ROM mappers; drives the standard ram_cs/addr mapper outputs.

---
 rtl/mapper_port_multicart.sv | 120 ++++++++++++
 tb/tb_mapper_port_multicart.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_port_multicart.sv
// mapper_port_multicart
//
// Multicart ROM mapper controlled by an I/O port (a generalisation of the Zemina
// 90-in-1 scheme). A Z80 OUT to PORT loads an 8-bit register. Bits [7:6] hold the
// mode and the low bits hold the 16KB page. CPU reads in 4000-BFFF are then
// translated into ROM byte addresses in 8KB blocks. The block number wraps with
// rom_mask, so any power-of-two ROM size works.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   enable               mapper selected; when 0 the block ignores all cycles
//   addr, data_in        CPU address / write data
//   mreq, iorq, rd, wr   Z80 bus strobes
//   rom_mask             (ROM size in 8KB blocks) - 1
//   ram_cs               ROM read select (combinational)
//   mem_addr             ROM byte address, all ones when ram_cs=0
//   io_data, io_oe       register readback (only when READBACK=1)
//   page_q, mode_q       current register fields
//
// Bus handshake: a register write is an I/O cycle with iorq & wr & addr[7:0]==PORT
// while enable=1. It is captured on the first rising edge where the cycle is seen.
// Later edges of the same OUT are ignored until wr or iorq drops. Reads need no
// handshake: ram_cs/mem_addr/io_data follow the inputs in the same cycle.
module mapper_port_multicart #(
    parameter logic [7:0] PORT        = 8'h77,
    parameter int         PAGE_BITS   = 6,
    parameter int         ADDR_W      = 27,
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter bit         READBACK    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [15:0]           addr,
    input  logic [7:0]            data_in,
    input  logic                  mreq,
    input  logic                  iorq,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_W-14:0]    rom_mask,
    output logic                  ram_cs,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            io_data,
    output logic                  io_oe,
    output logic [PAGE_BITS-1:0]  page_q,
    output logic [1:0]            mode_q
);

    localparam int BW = ADDR_W - 13;   // block number width
    localparam int IW = PAGE_BITS + 1; // block index width (page in 8KB units)

    logic                 wr_seen_q;
    logic                 wr_seen_d;
    logic [PAGE_BITS-1:0] page_d;
    logic [1:0]           mode_d;

    logic                 io_hit;
    logic                 mapped;
    logic [IW-1:0]        p;
    logic [IW-1:0]        idx;
    logic [BW-1:0]        blk;
    logic [5:0]           page6;

    assign io_hit = enable & iorq & (addr[7:0] == PORT);

    // Register write path. wr_seen tracks the OUT cycle so that a write held over
    // several clocks loads the register only once.
    always_comb begin
        page_d    = page_q;
        mode_d    = mode_q;
        wr_seen_d = io_hit & wr;
        if (io_hit && wr && !wr_seen_q) begin
            // The page field is never wider than data_in[5:0]. Wider pages are zero-extended.
            page_d = PAGE_BITS'(data_in[5:0]);
            mode_d = data_in[7:6];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            page_q    <= PAGE_BITS'(RESET_VALUE[5:0]);
            mode_q    <= RESET_VALUE[7:6];
            wr_seen_q <= 1'b0;
        end else begin
            page_q    <= page_d;
            mode_q    <= mode_d;
            wr_seen_q <= wr_seen_d;
        end
    end

    // 4000-BFFF is the only mapped window: exactly one of A15/A14 is set.
    assign mapped = addr[15] ^ addr[14];
    assign ram_cs = enable & mreq & rd & mapped;

    // Block index in 8KB units. addr[15] selects the upper 16KB and addr[13] selects
    // the 8KB half within it.
    always_comb begin
        p = {page_q, 1'b0};
        case (mode_q)
            // 32KB mode: bit 1 of the index follows the upper/lower 16KB window.
            2'b10: begin
                if (addr[15])
                    idx = p | IW'(2) | IW'(addr[13]);
                else
                    idx = (p & ~IW'(2)) | IW'(addr[13]);
            end
            // Namco layout: 6000 and 8000 map the odd block, 4000 and A000 map the even block.
            2'b11:   idx = p | IW'(addr[15] ^ addr[13]);
            default: idx = p | IW'(addr[13]);
        endcase
    end

    assign blk      = BW'(idx) & rom_mask;
    assign mem_addr = ram_cs ? {blk, addr[12:0]} : {ADDR_W{1'b1}};

    assign page6   = 6'(page_q);
    assign io_oe   = READBACK & io_hit & rd & ~wr;
    assign io_data = io_oe ? {mode_q, page6} : 8'hFF;

endmodule

// File: tb/tb_mapper_port_multicart.sv
// Testbench for mapper_port_multicart (defaults, READBACK=1).
// Stimulus is driven 1ns after the rising edge. Outputs are checked on the falling edge.
module tb_mapper_port_multicart;

    localparam int ADDR_W = 27;
    localparam int BW     = ADDR_W - 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [15:0]       addr = '0;
    logic [7:0]        data_in = '0;
    logic              mreq = 1'b0;
    logic              iorq = 1'b0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [BW-1:0]     rom_mask = '1;
    logic              ram_cs;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        io_data;
    logic              io_oe;
    logic [5:0]        page_q;
    logic [1:0]        mode_q;

    mapper_port_multicart #(.READBACK(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
        .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .rom_mask(rom_mask),
        .ram_cs(ram_cs), .mem_addr(mem_addr), .io_data(io_data), .io_oe(io_oe),
        .page_q(page_q), .mode_q(mode_q)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // The register contents as the CPU sees them after each completed OUT.
    int m_page = 0;
    int m_mode = 0;
    bit model_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_mem_addr(input logic [15:0] a);
        int s;
        int b;
        s = int'(a[15:13]);
        case (m_mode)
            2:       b = (m_page & ~1) * 2 + (s - 2);                // aligned 32KB window
            3:       b = m_page * 2 + ((s == 3 || s == 4) ? 1 : 0);  // Namco order
            default: b = m_page * 2 + (s & 1);
        endcase
        b = b % (int'(rom_mask) + 1);
        return 32'(b * 8192 + int'(a[12:0]));
    endfunction

    // Compare every cycle once the model is initialised.
    always @(negedge clk) begin
        if (model_valid) begin
            int  s;
            bit  exp_cs;
            bit  hit;
            bit  exp_oe;
            logic [31:0] exp_addr;
            logic [7:0]  exp_data;
            s        = int'(addr[15:13]);
            exp_cs   = enable && mreq && rd && (s >= 2 && s <= 5);
            exp_addr = exp_cs ? model_mem_addr(addr) : 32'h07FF_FFFF;
            hit      = enable && iorq && (addr[7:0] == 8'h77);
            exp_oe   = hit && rd && !wr;
            exp_data = exp_oe ? 8'((m_mode << 6) | m_page) : 8'hFF;
            chk("ram_cs", 32'(ram_cs), 32'(exp_cs));
            chk("mem_addr", 32'(mem_addr), exp_addr);
            chk("io_oe", 32'(io_oe), 32'(exp_oe));
            chk("io_data", 32'(io_data), 32'(exp_data));
            chk("page_q", 32'(page_q), 32'(m_page));
            chk("mode_q", 32'(mode_q), 32'(m_mode));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_sigs();
        mreq = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    // OUT held for n clocks. The data changes to d_later after the first edge.
    task automatic io_out(input logic [7:0] d, input int n, input bit en, input logic [7:0] d_later);
        logic [7:0] hi;
        hi = 8'($urandom);
        tick();
        idle_sigs();
        enable = en; iorq = 1'b1; wr = 1'b1; addr = {hi, 8'h77}; data_in = d;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0 && en) begin
                m_page = int'(d[5:0]);
                m_mode = int'(d[7:6]);
            end
            if (i < n - 1) data_in = d_later;
            else idle_sigs();
        end
    endtask

    task automatic do_reset(input bit with_wr);
        tick();
        idle_sigs();
        reset = 1'b1;
        if (with_wr) begin
            enable = 1'b1; iorq = 1'b1; wr = 1'b1; addr = 16'h0077; data_in = 8'h2A;
        end
        tick();
        m_page = 0;
        m_mode = 0;
        reset = 1'b0;
        idle_sigs();
    endtask

    task automatic lit_read(input logic [15:0] a, input logic exp_cs, input logic [31:0] exp_addr);
        tick();
        idle_sigs();
        enable = 1'b1; mreq = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        #1;
        chk("lit_ram_cs", 32'(ram_cs), 32'(exp_cs));
        chk("lit_mem_addr", 32'(mem_addr), exp_addr);
    endtask

    task automatic lit_in(input logic [7:0] exp);
        tick();
        idle_sigs();
        enable = 1'b1; iorq = 1'b1; rd = 1'b1; addr = 16'h1277;
        @(negedge clk);
        #1;
        chk("lit_io_oe", 32'(io_oe), 32'h1);
        chk("lit_io_data", 32'(io_data), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_valid = 1'b1;

        // Directed cases with hand-computed results
        lit_read(16'h4000, 1'b1, 32'h0000_0000);
        lit_read(16'hA000, 1'b1, 32'h0000_2000);
        lit_read(16'hC000, 1'b0, 32'h07FF_FFFF);
        lit_read(16'h0000, 1'b0, 32'h07FF_FFFF);
        io_out(8'h05, 3, 1'b1, 8'h3F);
        lit_in(8'h05);
        lit_read(16'h6000, 1'b1, 32'h0001_6000);
        lit_read(16'h8000, 1'b1, 32'h0001_4000);
        io_out(8'h85, 1, 1'b1, 8'h00);
        lit_read(16'h4000, 1'b1, 32'h0001_0000);
        lit_read(16'h6000, 1'b1, 32'h0001_2000);
        lit_read(16'h8000, 1'b1, 32'h0001_4000);
        lit_read(16'hA000, 1'b1, 32'h0001_6000);
        io_out(8'hC5, 2, 1'b1, 8'h11);
        lit_read(16'h8000, 1'b1, 32'h0001_6000);
        lit_read(16'hA000, 1'b1, 32'h0001_4000);
        lit_read(16'h4000, 1'b1, 32'h0001_4000);
        lit_in(8'hC5);
        io_out(8'h12, 1, 1'b0, 8'h12);
        lit_in(8'hC5);
        rom_mask = 14'h000F;
        io_out(8'h3F, 1, 1'b1, 8'h00);
        lit_read(16'h4000, 1'b1, 32'h0001_C000);
        rom_mask = '1;
        do_reset(1'b1);
        lit_in(8'h00);

        // Randomized traffic
        for (int it = 0; it < 2000; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                tick();
                enable = ($urandom_range(0, 7) != 0);
                mreq = 1'($urandom);
                rd = ($urandom_range(0, 3) != 0);
                wr = 1'($urandom);
                iorq = 1'b0;
                addr = 16'($urandom);
            end else if (op == 5) begin
                logic [7:0] lo;
                logic [7:0] hi;
                lo = 8'($urandom);
                hi = 8'($urandom);
                tick();
                enable = ($urandom_range(0, 7) != 0);
                mreq = 1'b0; iorq = 1'b1; rd = 1'b1; wr = 1'b0;
                addr = {hi, ($urandom_range(0, 1) == 1) ? 8'h77 : lo};
            end else if (op <= 7) begin
                io_out(8'($urandom), $urandom_range(1, 3), ($urandom_range(0, 3) != 0), 8'($urandom));
            end else if (op == 8) begin
                rom_mask = BW'((1 << $urandom_range(0, BW)) - 1);
            end else if ($urandom_range(0, 9) == 0) begin
                do_reset(1'($urandom));
            end
        end

        tick();
        idle_sigs();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
